// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry layout and register-file packing for the reorder buffer.
// Tag 0 (STATE_READY) means the architectural value lives in the register file.
package reorder_buffer_pkg;
   localparam int TAG_W = 5;
   localparam int REG_W = 32;
   localparam int RF_W  = TAG_W + REG_W;

   localparam logic [TAG_W-1:0] STATE_READY = 5'd0;

   typedef struct packed {
      logic             valid;
      logic             done;
      logic [TAG_W-1:0] rd;
      logic [REG_W-1:0] value;
   } rob_entry_t;

   function automatic logic [RF_W-1:0] rf_pack(input logic [TAG_W-1:0] state,
                                               input logic [REG_W-1:0] value);
      return {state, value};
   endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / register-file bundle around the reorder buffer.
// master = core side driving requests, slave = the reorder buffer itself.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic             alloc_valid;
   logic [TAG_W-1:0] alloc_rd;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             rename_we;
   logic [TAG_W-1:0] rename_addr;
   logic [RF_W-1:0]  rename_data;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [REG_W-1:0] cdb_value;
   logic [TAG_W-1:0] query_tag1, query_tag2;
   logic             query_ready1, query_ready2;
   logic [REG_W-1:0] query_value1, query_value2;
   logic             commit_valid;
   logic [TAG_W-1:0] commit_tag;
   logic             commit_we;
   logic [TAG_W-1:0] commit_addr;
   logic [RF_W-1:0]  commit_data;

   modport slave (
      input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, query_tag1, query_tag2,
      output alloc_ready, alloc_tag, rename_we, rename_addr, rename_data,
             query_ready1, query_ready2, query_value1, query_value2,
             commit_valid, commit_tag, commit_we, commit_addr, commit_data
   );

   modport master (
      output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, query_tag1, query_tag2,
      input  alloc_ready, alloc_tag, rename_we, rename_addr, rename_data,
             query_ready1, query_ready2, query_value1, query_value2,
             commit_valid, commit_tag, commit_we, commit_addr, commit_data
   );
endinterface

// File: rtl/reorder_buffer_tag_match.sv
// DEPTH-way tag compare: reports whether the tagged entry is pending or done and its value.
// Entry i carries tag i+1, so tag 0 never matches.
module rob_tag_match
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  rob_entry_t [DEPTH-1:0] ents,
   input  logic [TAG_W-1:0]       tag,
   output logic                   pend,
   output logic                   done,
   output logic [REG_W-1:0]       value
);
   always_comb begin
      pend  = 1'b0;
      done  = 1'b0;
      value = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tag == TAG_W'(i + 1)) begin
            pend  = ents[i].valid & ~ents[i].done;
            done  = ents[i].valid &  ents[i].done;
            value = ents[i].value;
         end
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, captures CDB results,
// answers operand lookups and retires the head with the correct post-commit rename state.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   reorder_buffer_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [TAG_W-1:0] DEPTH_T  = TAG_W'(DEPTH);

   rob_entry_t [DEPTH-1:0]   ents;
   logic [31:0][TAG_W-1:0]   latest;
   logic [IDX_W-1:0]         head, tail;
   logic [TAG_W-1:0]         count;

   logic             go, alloc_fire, same_rd;
   logic [TAG_W-1:0] head_tag, new_state;
   rob_entry_t       head_ent;
   logic             cdb_pend, cdb_done, q1_pend, q1_done, q2_pend, q2_done;
   logic [REG_W-1:0] cdb_old, q1_val, q2_val;

   rob_tag_match #(.DEPTH(DEPTH)) u_cdb (.ents(ents), .tag(bus.cdb_tag),
      .pend(cdb_pend), .done(cdb_done), .value(cdb_old));
   rob_tag_match #(.DEPTH(DEPTH)) u_q1 (.ents(ents), .tag(bus.query_tag1),
      .pend(q1_pend), .done(q1_done), .value(q1_val));
   rob_tag_match #(.DEPTH(DEPTH)) u_q2 (.ents(ents), .tag(bus.query_tag2),
      .pend(q2_pend), .done(q2_done), .value(q2_val));

   assign go          = rdy & ~flush;
   assign bus.alloc_ready = go & (count < DEPTH_T);
   assign bus.alloc_tag   = TAG_W'(tail) + TAG_W'(1);
   assign alloc_fire      = bus.alloc_valid & bus.alloc_ready;

   assign bus.rename_we   = alloc_fire & (bus.alloc_rd != '0);
   assign bus.rename_addr = bus.alloc_rd;
   assign bus.rename_data = rf_pack(bus.alloc_tag, '0);

   // Same-cycle CDB broadcast wins over stored state so dispatch sees results with no delay
   always_comb begin
      bus.query_ready1 = (bus.query_tag1 != '0) &
                         ((bus.cdb_valid & (bus.cdb_tag == bus.query_tag1)) | q1_done);
      bus.query_value1 = (bus.cdb_valid & (bus.cdb_tag == bus.query_tag1)) ? bus.cdb_value : q1_val;
      bus.query_ready2 = (bus.query_tag2 != '0) &
                         ((bus.cdb_valid & (bus.cdb_tag == bus.query_tag2)) | q2_done);
      bus.query_value2 = (bus.cdb_valid & (bus.cdb_tag == bus.query_tag2)) ? bus.cdb_value : q2_val;
   end

   assign head_ent = ents[head];
   assign head_tag = TAG_W'(head) + TAG_W'(1);

   // A younger writer (including one allocating this very cycle) keeps ownership of rd
   always_comb begin
      same_rd   = alloc_fire & (bus.alloc_rd == head_ent.rd) & (head_ent.rd != '0);
      new_state = latest[head_ent.rd];
      if (same_rd)
         new_state = bus.alloc_tag;
      else if (latest[head_ent.rd] == head_tag)
         new_state = STATE_READY;
   end

   assign bus.commit_valid = go & (count != '0) & head_ent.done;
   assign bus.commit_tag   = head_tag;
   assign bus.commit_we    = bus.commit_valid & (head_ent.rd != '0);
   assign bus.commit_addr  = head_ent.rd;
   assign bus.commit_data  = rf_pack(new_state, head_ent.value);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ents   <= '0;
         latest <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (rdy) begin
         if (flush) begin
            ents   <= '0;
            latest <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
         end else begin
            if (bus.cdb_valid & cdb_pend) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (bus.cdb_tag == TAG_W'(i + 1)) begin
                     ents[i].done  <= 1'b1;
                     ents[i].value <= bus.cdb_value;
                  end
               end
            end
            if (bus.commit_valid) begin
               ents[head].valid <= 1'b0;
               ents[head].done  <= 1'b0;
               head <= (head == LAST_IDX) ? '0 : head + IDX_W'(1);
               if ((head_ent.rd != '0) & ~same_rd & (latest[head_ent.rd] == head_tag))
                  latest[head_ent.rd] <= STATE_READY;
            end
            if (alloc_fire) begin
               ents[tail] <= '{valid: 1'b1, done: 1'b0, rd: bus.alloc_rd, value: '0};
               tail <= (tail == LAST_IDX) ? '0 : tail + IDX_W'(1);
               if (bus.alloc_rd != '0)
                  latest[bus.alloc_rd] <= bus.alloc_tag;
            end
            count <= count + TAG_W'(alloc_fire) - TAG_W'(bus.commit_valid);
         end
      end
   end
endmodule
